// File: rtl/alu_issue.sv
// Decode/issue stage for ADD/ADDI with 32x32 regfile, write-back port and RAW scoreboard.
// Latency 1 cycle (transfer edge N -> bundle valid N+1); stalls on RAW hazard or a held bundle.
package rv;
  typedef enum logic {
    ADD  = 1'b0,
    ADDI = 1'b1
  } RV32_INSTRUCTION;
endpackage

module alu_issue #(
  parameter bit RESET_REGFILE = 1'b1,
  parameter bit SCOREBOARD_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [31:0]            instr,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output rv::RV32_INSTRUCTION    iss_opcode,
  output logic [31:0]            iss_op1,
  output logic [31:0]            iss_op2,
  output logic [31:0]            iss_imm,
  output logic [4:0]             iss_rd,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic [31:0]            wb_data,
  output logic                   illegal
);

  logic [31:0]         regfile_q [32];
  logic [31:0]         regfile_d [32];
  logic [31:0]         busy_q, busy_d;
  logic                iss_valid_q, iss_valid_d;
  rv::RV32_INSTRUCTION iss_opcode_q, iss_opcode_d;
  logic [31:0]         iss_op1_q, iss_op1_d;
  logic [31:0]         iss_op2_q, iss_op2_d;
  logic [31:0]         iss_imm_q, iss_imm_d;
  logic [4:0]          iss_rd_q, iss_rd_d;
  logic                illegal_q, illegal_d;

  logic [4:0]  rs1, rs2, rd;
  logic        is_add, is_addi, legal;
  logic        haz1, haz2, hazard, out_free;
  logic        xfer, issue;
  logic        wb_en;
  logic [31:0] rs1_val, rs2_val, imm_sx;

  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm_sx = {{20{instr[31]}}, instr[31:20]};

  assign is_add  = (instr[6:0] == 7'b0110011) && (instr[14:12] == 3'b000) && (instr[31:25] == 7'b0000000);
  assign is_addi = (instr[6:0] == 7'b0010011) && (instr[14:12] == 3'b000);
  assign legal   = is_add || is_addi;

  assign wb_en = wb_valid && !rst;

  // A register being written back this cycle is already resolved, so it is not a hazard.
  assign haz1   = (rs1 != 5'd0) && busy_q[rs1] && !(wb_valid && (wb_rd == rs1));
  assign haz2   = is_add && (rs2 != 5'd0) && busy_q[rs2] && !(wb_valid && (wb_rd == rs2));
  assign hazard = SCOREBOARD_EN && legal && (haz1 || haz2);

  assign out_free    = !iss_valid_q || iss_ready;
  assign instr_ready = !rst && out_free && !hazard;
  assign xfer        = instr_valid && instr_ready;
  assign issue       = xfer && legal;

  always_comb begin
    rs1_val = regfile_q[rs1];
    if (rs1 == 5'd0)
      rs1_val = 32'd0;
    else if (wb_valid && (wb_rd == rs1))
      rs1_val = wb_data;

    rs2_val = regfile_q[rs2];
    if (rs2 == 5'd0)
      rs2_val = 32'd0;
    else if (wb_valid && (wb_rd == rs2))
      rs2_val = wb_data;
  end

  always_comb begin
    regfile_d = regfile_q;
    if (wb_en && (wb_rd != 5'd0))
      regfile_d[wb_rd] = wb_data;
  end

  // Clear before set so a same-index issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_en)
      busy_d[wb_rd] = 1'b0;
    if (issue && (rd != 5'd0))
      busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    iss_valid_d  = iss_valid_q;
    iss_opcode_d = iss_opcode_q;
    iss_op1_d    = iss_op1_q;
    iss_op2_d    = iss_op2_q;
    iss_imm_d    = iss_imm_q;
    iss_rd_d     = iss_rd_q;
    if (issue) begin
      iss_valid_d  = 1'b1;
      iss_opcode_d = is_add ? rv::ADD : rv::ADDI;
      iss_op1_d    = rs1_val;
      iss_op2_d    = is_add ? rs2_val : 32'd0;
      iss_imm_d    = is_add ? 32'd0 : imm_sx;
      iss_rd_d     = rd;
    end else if (iss_valid_q && iss_ready) begin
      iss_valid_d = 1'b0;
    end
    illegal_d = xfer && !legal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid_q  <= 1'b0;
      iss_opcode_q <= rv::ADD;
      iss_op1_q    <= 32'd0;
      iss_op2_q    <= 32'd0;
      iss_imm_q    <= 32'd0;
      iss_rd_q     <= 5'd0;
      illegal_q    <= 1'b0;
      busy_q       <= 32'd0;
    end else begin
      iss_valid_q  <= iss_valid_d;
      iss_opcode_q <= iss_opcode_d;
      iss_op1_q    <= iss_op1_d;
      iss_op2_q    <= iss_op2_d;
      iss_imm_q    <= iss_imm_d;
      iss_rd_q     <= iss_rd_d;
      illegal_q    <= illegal_d;
      busy_q       <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (rst && RESET_REGFILE)
        regfile_q[i] <= 32'd0;
      else
        regfile_q[i] <= regfile_d[i];
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_opcode = iss_opcode_q;
  assign iss_op1    = iss_op1_q;
  assign iss_op2    = iss_op2_q;
  assign iss_imm    = iss_imm_q;
  assign iss_rd     = iss_rd_q;
  assign illegal    = illegal_q;

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Decode/issue stage that feeds the ALU, and the write-back end that takes its results. It accepts raw RV32I instruction words over a valid/ready handshake and decodes ADD and ADDI. It reads operands from an internal 32x32 register file and presents a registered opcode/op1/op2/imm bundle to the ALU. ALU results come back on a write-back port; a per-register scoreboard stalls read-after-write hazards.

Parameters:
RESET_REGFILE, 1, 1 = all x1..x31 cleared to 0 on rst; 0 = contents undefined after reset.
SCOREBOARD_EN, 1, 1 = RAW stall logic active; 0 = no stalls, and the bench guarantees no hazards.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
instr_valid  input  1  instruction word valid
instr_ready  output  1  stage accepts instr this cycle
instr  input  32  RV32I instruction word
iss_valid  output  1  issue bundle valid
iss_ready  input  1  ALU side accepts bundle
iss_opcode  output  rv::RV32_INSTRUCTION  decoded op, ADD or ADDI
iss_op1  output  32  rs1 value
iss_op2  output  32  rs2 value (ADD); 0 for ADDI
iss_imm  output  32  sign-extended I-immediate (ADDI); 0 for ADD
iss_rd  output  5  destination register
wb_valid  input  1  write-back strobe
wb_rd  input  5  write-back register index
wb_data  input  32  write-back value (ALU result)
illegal  output  1  one-cycle pulse: unsupported instruction consumed

Behaviour:
- Reset (sync, rst=1 at clk edge): iss_valid=0; iss_opcode=ADD; iss_op1, iss_op2 and iss_imm=0; iss_rd=0; illegal=0; scoreboard all clear; regfile cleared if RESET_REGFILE. An in-flight bundle is discarded. instr_ready=0 while rst=1.
- Decode:
  - ADD = opcode 0110011, funct3 000, funct7 0000000.
  - ADDI = opcode 0010011, funct3 000.
  - rd=[11:7], rs1=[19:15], rs2=[24:20]; imm = sign-extend instr[31:20].
  - Anything else is illegal.
- Output register free: out_free = !iss_valid || iss_ready.
- Hazard (SCOREBOARD_EN=1):
  - rs1 != 0 with busy[rs1], or (ADD and rs2 != 0 with busy[rs2]).
  - A register that is being written back in the same cycle (wb_valid && wb_rd == rs) is not a hazard.
  - Illegal instructions never raise a hazard.
- instr_ready = !rst && out_free && !hazard (combinational). A transfer occurs when instr_valid && instr_ready.
- Latency: a legal transfer at edge N gives iss_valid=1 with the bundle stable from N+1. The bundle holds until the cycle where iss_valid && iss_ready. Back-to-back issue needs iss_ready=1 every cycle, giving 1 instr/cycle.
- Illegal transfer: consumed; iss_valid is not set by it; illegal=1 for exactly the following cycle; no scoreboard or regfile change.
- Operand read:
  - x0 reads 0.
  - If wb_valid && wb_rd == rs && wb_rd != 0 in the transfer cycle, the operand takes wb_data (bypass). Otherwise it takes the regfile value.
- Regfile write: on wb_valid && wb_rd != 0, regfile[wb_rd] <= wb_data. Writes to x0 are ignored.
- Scoreboard:
  - On a legal transfer with rd != 0, busy[rd] is set.
  - On wb_valid, busy[wb_rd] is cleared.
  - If the set and the clear hit the same index in the same cycle, set wins.
  - busy[0] is always 0.
- Write-back has no ready; it is always accepted, including during stall. wb_valid while rst=1 is ignored.
- Out-of-order wb_rd (not busy) simply writes the regfile.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with iss_ready=1 -> next cycle iss_valid=1, ADDI, op1=0, imm=5, rd=1; busy[1]=1.
- ADDI x1,x0,-1 (0xFFF00093) -> iss_imm=0xFFFFFFFF, iss_op2=0; wb rd=1 data=0xFFFFFFFF writes x1; a later ADD x3,x1,x0 gives op1=0xFFFFFFFF.
- RAW stall: issue ADDI x1, then present ADD x3,x1,x2 (0x002081B3) -> instr_ready=0 until wb_valid rd=1 data=7. In that wb cycle the instr is accepted with op1=7 via bypass.
- Backpressure: iss_ready=0 for 3 cycles with a bundle valid -> bundle held constant, instr_ready=0; iss_ready=1 -> next instr accepted the same cycle.
- Illegal SUB (0x402081B3) -> accepted, illegal pulses 1 cycle, iss_valid stays 0, busy[3] stays 0.
- rst asserted while iss_valid=1 and busy[1]=1 -> next cycle iss_valid=0, scoreboard clear, x1 reads 0 (RESET_REGFILE=1).
